// File: rtl/aes_ct_output_buffer.sv
// -----------------------------------------------------------------------------
// aes_ct_output_buffer
//
// Sits behind the pipelined AES-128 encryptor. Each ciphertext arrives on a
// one-cycle `done` pulse and goes into a small block FIFO. The head block is
// serialized as four 32-bit words (MSW first) over a valid/ready stream.
// The encryptor cannot be stalled, so the block tracks how many blocks are
// in flight inside it. `can_start` is withheld whenever a new block could
// find the FIFO without room when it arrives.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       encryptor start (a block entered the pipeline this cycle)
//   done        encryptor output-valid pulse
//   data_out    128-bit ciphertext, sampled when done=1
//   can_start   upstream may assert start this cycle
//   m_word      current output word (0 when m_valid=0)
//   m_valid     m_word is valid
//   m_ready     consumer accepts m_word
//   m_last      m_word is word 3 of its block
//   fifo_count  blocks currently stored
//   overflow    sticky: a ciphertext was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module aes_ct_output_buffer #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         done,
  input  logic [127:0]                 data_out,
  output logic                         can_start,
  output logic [31:0]                  m_word,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  // Sum width wide enough for count + in_flight without wrapping.
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  // Storage and state registers.
  logic [127:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    word_idx_q, word_idx_d;
  logic [IW-1:0] in_flight_q, in_flight_d;
  logic          overflow_q, overflow_d;

  // Combinational helpers.
  logic [127:0]  head_s;
  logic          valid_s;
  logic          xfer_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_accept_s;
  logic          drop_s;
  logic [SW-1:0] occupancy_s;
  logic [31:0]   word_s;

  // Handshake, push/pop and occupancy decode.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    valid_s     = (count_q != {CW{1'b0}});
    xfer_s      = valid_s & m_ready;
    pop_s       = xfer_s & (word_idx_q == 2'd3);
    full_s      = (count_q == CW'(DEPTH));
    // At full, a same-cycle pop frees the slot the write lands in
    // (wr_ptr == rd_ptr when full), so the write is still accepted.
    wr_accept_s = done & (~full_s | pop_s);
    drop_s      = done & full_s & ~pop_s;
    occupancy_s = SW'(count_q) + SW'(in_flight_q);
  end

  // Next-state for pointers, count, word index, in-flight and overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    in_flight_d = in_flight_q;
    overflow_d  = overflow_q | drop_s;

    // Pointers are PW bits wide and DEPTH is a power of two, so the
    // natural roll-over gives the modulo-DEPTH wrap.
    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // 2-bit index wraps 3 -> 0 on its own.
    if (xfer_s) begin
      word_idx_d = word_idx_q + 2'd1;
    end else begin
      word_idx_d = word_idx_q;
    end

    case ({wr_accept_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    // Saturates at both ends: a stray done at zero must not wrap the
    // counter and permanently block can_start.
    case ({start, done})
      2'b10: begin
        if (in_flight_q != IW'(MAX_INFLIGHT)) begin
          in_flight_d = in_flight_q + {{(IW-1){1'b0}}, 1'b1};
        end else begin
          in_flight_d = in_flight_q;
        end
      end
      2'b01: begin
        if (in_flight_q != {IW{1'b0}}) begin
          in_flight_d = in_flight_q - {{(IW-1){1'b0}}, 1'b1};
        end else begin
          in_flight_d = {IW{1'b0}};
        end
      end
      default: in_flight_d = in_flight_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      word_idx_q  <= 2'd0;
      in_flight_q <= {IW{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  // Block storage; cleared on reset so no stale ciphertext survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 128'd0;
      end
    end else begin
      if (wr_accept_s) begin
        mem_q[wr_ptr_q] <= data_out;
      end
    end
  end

  // Word select from the head block, most significant word first.
  always_comb begin
    word_s = 32'd0;
    case (word_idx_q)
      2'd0:    word_s = head_s[127:96];
      2'd1:    word_s = head_s[95:64];
      2'd2:    word_s = head_s[63:32];
      2'd3:    word_s = head_s[31:0];
      default: word_s = 32'd0;
    endcase
  end

  // Output drive; all outputs derive from registered state only.
  always_comb begin
    m_valid    = valid_s;
    m_last     = valid_s & (word_idx_q == 2'd3);
    fifo_count = count_q;
    overflow   = overflow_q;
    can_start  = (occupancy_s < SW'(DEPTH));
    if (valid_s) begin
      m_word = word_s;
    end else begin
      m_word = 32'd0;
    end
  end

endmodule

// File: tb/tb_aes_ct_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_aes_ct_output_buffer
//
// Directed bench for aes_ct_output_buffer (DEPTH=4). A queue-based reference
// model tracks stored blocks, the word position within the head block, the
// in-flight count and the sticky overflow flag; a compare process checks
// every DUT output against it on each falling edge. Directed sequences add
// literal expectations for the test-plan scenarios.
// -----------------------------------------------------------------------------
module tb_aes_ct_output_buffer;

  logic         clk;
  logic         reset;
  logic         start;
  logic         done;
  logic [127:0] data_out;
  logic         can_start;
  logic [31:0]  m_word;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [2:0]   fifo_count;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  aes_ct_output_buffer #(.DEPTH(4), .MAX_INFLIGHT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .data_out   (data_out),
    .can_start  (can_start),
    .m_word     (m_word),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] mq[$];
  int           m_widx     = 0;
  int           m_inflight = 0;
  bit           m_ovf      = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_widx     = 0;
      m_inflight = 0;
      m_ovf      = 1'b0;
    end else begin
      bit xfer, pop, accept;
      xfer   = (mq.size() != 0) && (m_ready === 1'b1);
      pop    = xfer && (m_widx == 3);
      accept = done && ((mq.size() < 4) || pop);
      if (start && !done) m_inflight = m_inflight + 1;
      else if (done && !start && m_inflight > 0) m_inflight = m_inflight - 1;
      if (xfer) m_widx = (m_widx + 1) % 4;
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back(data_out);
      else if (done) m_ovf = 1'b1;
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      logic [127:0] h;
      logic [31:0]  ew;
      bit           ev;
      ev = (mq.size() != 0);
      h  = ev ? mq[0] : 128'd0;
      ew = ev ? h[127 - 32*m_widx -: 32] : 32'd0;
      check("cmp_m_valid",    128'(m_valid),    128'(ev));
      check("cmp_m_word",     128'(m_word),     128'(ew));
      check("cmp_m_last",     128'(m_last),     128'(ev && (m_widx == 3)));
      check("cmp_fifo_count", 128'(fifo_count), 128'(mq.size()));
      check("cmp_overflow",   128'(overflow),   128'(m_ovf));
      check("cmp_can_start",  128'(can_start),  128'((mq.size() + m_inflight) < 4));
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] blk [6];
  logic [31:0]  t1w [4];
  logic         pat [7];
  logic [127:0] exp_q[$];
  logic [127:0] t1_blk;
  logic [127:0] bad_blk;
  logic [127:0] c_blk;
  logic [127:0] d_blk;

  task automatic step();
    @(negedge clk);
  endtask

  // Drain exp_q with the ready pattern, checking each word literally.
  task automatic drain(input string name);
    int wi  = 0;
    int cyc = 0;
    logic [127:0] h;
    while (exp_q.size() != 0 && cyc < 200) begin
      h = exp_q[0];
      check({name, "_valid"}, 128'(m_valid), 128'(1'b1));
      check({name, "_word"},  128'(m_word),  128'(h[127 - 32*wi -: 32]));
      check({name, "_last"},  128'(m_last),  128'(wi == 3));
      m_ready = pat[cyc % 7];
      if (m_ready) begin
        wi++;
        if (wi == 4) begin
          wi = 0;
          void'(exp_q.pop_front());
        end
      end
      cyc++;
      step();
    end
    m_ready = 1'b0;
    check({name, "_budget"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_blk  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    t1w     = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    blk[0]  = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    blk[1]  = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    blk[2]  = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    blk[3]  = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    blk[4]  = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
    blk[5]  = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;
    bad_blk = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    c_blk   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    d_blk   = 128'h11111111_22222222_33333333_44444444;

    reset = 1'b1; start = 1'b0; done = 1'b0; data_out = 128'd0; m_ready = 1'b0;
    step(); step();
    // Reset state.
    check("rst_m_valid",    128'(m_valid),    128'(1'b0));
    check("rst_m_last",     128'(m_last),     128'(1'b0));
    check("rst_m_word",     128'(m_word),     128'(32'd0));
    check("rst_can_start",  128'(can_start),  128'(1'b1));
    check("rst_fifo_count", 128'(fifo_count), 128'(3'd0));
    check("rst_overflow",   128'(overflow),   128'(1'b0));
    #2 reset = 1'b0;
    step();

    // 1: single block with m_ready=1.
    m_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; done = 1'b1; data_out = t1_blk;
    step();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t1_word", 128'(m_word), 128'(t1w[i]));
      check("t1_last", 128'(m_last), 128'(i == 3));
      step();
    end
    check("t1_count_zero", 128'(fifo_count), 128'(3'd0));
    m_ready = 1'b0;

    // 2: in-flight throttle.
    for (int i = 0; i < 4; i++) begin
      check("t2_can_start_open", 128'(can_start), 128'(1'b1));
      start = 1'b1;
      step();
    end
    start = 1'b0;
    check("t2_can_start_closed", 128'(can_start), 128'(1'b0));
    for (int i = 0; i < 4; i++) begin
      done = 1'b1; data_out = blk[i];
      step();
    end
    done = 1'b0;
    check("t2_count_full",    128'(fifo_count), 128'(3'd4));
    check("t2_can_start_full", 128'(can_start), 128'(1'b0));
    check("t2_head_word",     128'(m_word), 128'(blk[0][127:96]));

    // Drain block 0 alone: room for one more block.
    m_ready = 1'b1;
    step(); step(); step();
    check("t2_last_w3", 128'(m_last), 128'(1'b1));
    step();
    check("t2_count_3",         128'(fifo_count), 128'(3'd3));
    check("t2_can_start_after", 128'(can_start),  128'(1'b1));

    // 4: refill to full, then push while popping at full.
    m_ready = 1'b0; done = 1'b1; data_out = blk[4];
    step();
    done = 1'b0;
    check("t4_count_full", 128'(fifo_count), 128'(3'd4));
    m_ready = 1'b1;
    step(); step(); step();
    check("t4_last_w3", 128'(m_last), 128'(1'b1));
    done = 1'b1; data_out = blk[5];
    step();
    done = 1'b0; m_ready = 1'b0;
    check("t4_count_stays", 128'(fifo_count), 128'(3'd4));
    check("t4_no_overflow", 128'(overflow),   128'(1'b0));
    check("t4_head_word",   128'(m_word),     128'(blk[2][127:96]));

    // 3: overflow at full with no pop.
    done = 1'b1; data_out = bad_blk;
    step();
    done = 1'b0;
    check("t3_count_stays", 128'(fifo_count), 128'(3'd4));
    check("t3_overflow",    128'(overflow),   128'(1'b1));
    step();
    check("t3_overflow_sticky", 128'(overflow), 128'(1'b1));
    check("t3_head_unchanged",  128'(m_word),   128'(blk[2][127:96]));

    // 5: drain in order under toggling backpressure; blk[5] comes out last.
    exp_q = '{blk[2], blk[3], blk[4], blk[5]};
    drain("t5_drain");
    check("t5_count_empty",     128'(fifo_count), 128'(3'd0));
    check("t5_overflow_sticky", 128'(overflow),   128'(1'b1));

    // 6: async reset in the middle of a block.
    start = 1'b1;
    step();
    start = 1'b0; done = 1'b1; data_out = c_blk;
    step();
    done = 1'b0; m_ready = 1'b1;
    step(); step();
    m_ready = 1'b0;
    check("t6_word2_before_rst", 128'(m_word), 128'(c_blk[63:32]));
    #2 reset = 1'b1;
    #1;
    check("t6_rst_m_valid",    128'(m_valid),    128'(1'b0));
    check("t6_rst_m_last",     128'(m_last),     128'(1'b0));
    check("t6_rst_m_word",     128'(m_word),     128'(32'd0));
    check("t6_rst_can_start",  128'(can_start),  128'(1'b1));
    check("t6_rst_fifo_count", 128'(fifo_count), 128'(3'd0));
    check("t6_rst_overflow",   128'(overflow),   128'(1'b0));
    step();
    #2 reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0; done = 1'b1; data_out = d_blk;
    step();
    done = 1'b0;
    check("t6_after_word0", 128'(m_word), 128'(d_blk[127:96]));
    check("t6_after_last",  128'(m_last), 128'(1'b0));
    exp_q = '{d_blk};
    drain("t6_drain");
    check("t6_count_empty", 128'(fifo_count), 128'(3'd0));

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
